// File: rtl/hyp_unit_if.sv
// hyp_unit_if: HYP coprocessor bus; start and operands in, result and busy out.
// Ports (signals): start_i, a_bi[7:0], b_bi[7:0] driven by the core (master);
//                  y_bo[8:0], busy_o driven by hyp_unit (slave).
interface hyp_unit_if;
    logic       start_i;
    logic [7:0] a_bi;
    logic [7:0] b_bi;
    logic [8:0] y_bo;
    logic       busy_o;
    modport master (output start_i, a_bi, b_bi, input y_bo, busy_o);
    modport slave (input start_i, a_bi, b_bi, output y_bo, busy_o);
endinterface

// File: rtl/hyp_unit.sv
// hyp_unit: multi-cycle y = floor(sqrt(a*a + b*b)) for 8-bit operands, 25-cycle busy window.
// Ports: clk, rst (sync, active-high); bus (hyp_unit_if.slave): start_i, a_bi, b_bi in;
//        y_bo, busy_o out.
// Optional: define HYP_UNIT_ROUND_EN to round the root to nearest instead of truncating.
module hyp_unit #(
    parameter int W_IN  = 8,
    parameter int W_OUT = 9
) (
    input logic       clk,
    input logic       rst,
    hyp_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MUL_A, MUL_B, SQRT} state_t;
    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [W_IN-1:0]   a_q, a_d, b_q, b_d;
    logic [17:0]       sum_q, sum_d;
    logic [18:0]       rem_q, rem_d;
    logic [W_OUT-1:0]  root_q, root_d, y_q, y_d;
    logic [W_IN-1:0]   op;
    logic [15:0]       pp;
    logic [20:0]       rem_sh, trial;
    logic              fits;
    always_comb begin
        op      = (state_q == MUL_A) ? a_q : b_q;
        pp      = op[cnt_q[2:0]] ? ({8'd0, op} << cnt_q[2:0]) : 16'd0;
        // Restoring root step: bring down the next radicand bit pair, try 4*root+1.
        rem_sh  = {rem_q, sum_q[17:16]};
        trial   = {10'd0, root_q, 2'b01};
        fits    = rem_sh >= trial;
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        rem_d   = rem_q;
        root_d  = root_q;
        y_d     = y_q;
        case (state_q)
            IDLE: if (bus.start_i) begin
                a_d     = bus.a_bi;
                b_d     = bus.b_bi;
                sum_d   = '0;
                rem_d   = '0;
                root_d  = '0;
                cnt_d   = '0;
                state_d = MUL_A;
            end
            MUL_A, MUL_B: begin
                sum_d   = sum_q + {2'b00, pp};
                cnt_d   = (cnt_q == 4'd7) ? 4'd0 : cnt_q + 4'd1;
                state_d = (cnt_q != 4'd7) ? state_q : (state_q == MUL_A) ? MUL_B : SQRT;
            end
            default: begin
                sum_d   = sum_q << 2;
                rem_d   = 19'(fits ? rem_sh - trial : rem_sh);
                root_d  = {root_q[7:0], fits};
                cnt_d   = (cnt_q == 4'd8) ? 4'd0 : cnt_q + 4'd1;
                if (cnt_q == 4'd8) begin
                    state_d = IDLE;
`ifdef HYP_UNIT_ROUND_EN
                    y_d = root_d + 9'(rem_d > {10'd0, root_d});
`else
                    y_d = root_d;
`endif
                end
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            rem_q   <= '0;
            root_q  <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            rem_q   <= rem_d;
            root_q  <= root_d;
            y_q     <= y_d;
        end
    end
    assign bus.y_bo   = y_q;
    assign bus.busy_o = state_q != IDLE;
endmodule

// File: tb/tb_hyp_unit.sv
// tb_hyp_unit: randomized self-checking bench for hyp_unit against an arithmetic reference.
module tb_hyp_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    hyp_unit_if bus ();
    hyp_unit dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    function automatic logic [8:0] ref_hyp(input int a, input int b);
        int s, r;
        s = a * a + b * b;
        r = 0;
        while ((r + 1) * (r + 1) <= s) r++;
`ifdef HYP_UNIT_ROUND_EN
        if (s - r * r > r) r++;
`endif
        return 9'(r);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts one op; optionally raises start_i again at busy cycle poke_at. Operands are
    // scrambled during busy to show they are not resampled.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int poke_at, input string nm);
        logic [8:0] prev, exp;
        int n;
        exp = ref_hyp(int'(a), int'(b));
        prev = bus.y_bo;
        bus.a_bi = a;
        bus.b_bi = b;
        bus.start_i = 1'b1;
        tick();
        n = 0;
        while (bus.busy_o && n < 40) begin
            checks++;
            if (bus.y_bo !== prev) begin
                errors++;
                $display("FAIL %s_hold: y_bo=%0d expected %0d at busy cycle %0d", nm, bus.y_bo, prev, n);
            end
            n++;
            bus.start_i = (n == poke_at);
            bus.a_bi = (n == poke_at) ? 8'd100 : 8'($urandom);
            bus.b_bi = (n == poke_at) ? 8'd100 : 8'($urandom);
            tick();
        end
        bus.start_i = 1'b0;
        checks++;
        if (n != 25) begin
            errors++;
            $display("FAIL %s_latency: busy cycles=%0d expected 25", nm, n);
        end
        checks++;
        if (bus.y_bo !== exp) begin
            errors++;
            $display("FAIL %s_result: a=%0d b=%0d y_bo=%0d expected %0d", nm, a, b, bus.y_bo, exp);
        end
    endtask

    task automatic test_reset();
        bus.start_i = 1'b1;
        bus.a_bi = 8'd9;
        bus.b_bi = 8'd9;
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.busy_o !== 1'b0 || bus.y_bo !== 9'd0) begin
            errors++;
            $display("FAIL reset: busy_o=%b y_bo=%0d expected 0 0", bus.busy_o, bus.y_bo);
        end
        bus.start_i = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        run_op(8'd3, 8'd4, -1, "basic");
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (bus.y_bo !== 9'd5 || bus.busy_o !== 1'b0) begin
                errors++;
                $display("FAIL idle_hold: y_bo=%0d busy_o=%b expected 5 0", bus.y_bo, bus.busy_o);
            end
            tick();
        end
    endtask

    task automatic test_corners();
        run_op(8'd255, 8'd255, -1, "max");
        run_op(8'd0, 8'd0, -1, "zero");
        run_op(8'd2, 8'd3, -1, "round13");
        run_op(8'd6, 8'd6, -1, "sum72");
        checks++;
        if (bus.y_bo !== 9'd8) begin
            errors++;
            $display("FAIL sum72_const: y_bo=%0d expected 8", bus.y_bo);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) run_op(8'($urandom), 8'($urandom), -1, "random");
    endtask

    task automatic test_busy_ignore();
        run_op(8'd3, 8'd4, 10, "busy_start");
    endtask

    task automatic test_reset_mid();
        bus.a_bi = 8'd200;
        bus.b_bi = 8'd100;
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        repeat (11) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bus.busy_o !== 1'b0 || bus.y_bo !== 9'd0) begin
            errors++;
            $display("FAIL reset_mid: busy_o=%b y_bo=%0d expected 0 0", bus.busy_o, bus.y_bo);
        end
        run_op(8'd8, 8'd15, -1, "after_reset");
    endtask

    task automatic test_back_to_back();
        int n;
        bus.a_bi = 8'd5;
        bus.b_bi = 8'd12;
        bus.start_i = 1'b1;
        for (int r = 0; r < 2; r++) begin
            tick();
            n = 0;
            while (bus.busy_o && n < 40) begin
                n++;
                tick();
            end
            checks++;
            if (n != 25 || bus.y_bo !== 9'd13) begin
                errors++;
                $display("FAIL b2b_run%0d: busy cycles=%0d y_bo=%0d expected 25 13", r, n, bus.y_bo);
            end
        end
        tick();
        checks++;
        if (bus.busy_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_gap: busy_o=%b expected 1 after one idle cycle", bus.busy_o);
        end
        bus.start_i = 1'b0;
        repeat (30) tick();
    endtask

    initial begin
        bus.start_i = 1'b0;
        bus.a_bi = '0;
        bus.b_bi = '0;
        test_reset();
        test_basic();
        test_corners();
        test_random();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hyp_unit.md
Name: hyp_unit

Overview:
Multi-cycle hypotenuse coprocessor for the HYP custom instruction: y = floor(sqrt(a*a + b*b)) for 8-bit unsigned operands.
- Sits directly downstream of the core's register file and control unit. Operands come from rs1[7:0] and rs2[7:0]; start comes from the control unit's start_calc.
- busy_o stalls the PC. y_bo feeds the write-back mux, which selects it in the cycle after busy falls.
- One shared shift-add multiplier squares each operand in turn; a digit-by-digit integer square root follows.

Parameters:
- W_IN, 8, operand width (fixed; other values unsupported)
- W_OUT, 9, result width, W_IN+1

Ports:
- clk  in  1  clock (already decided)
- rst  in  1  reset, synchronous, active-high (already decided)
- start_i  in  1  start request, sampled only in IDLE
- a_bi  in  8  operand a, unsigned
- b_bi  in  8  operand b, unsigned
- y_bo  out  9  result, unsigned
- busy_o  out  1  high while an operation is in progress

Behaviour:
- Reset values: state=IDLE, y_bo=0, busy_o=0, all internal datapath registers 0. rst has priority over every other input, including a simultaneous start_i.
- busy_o = (state != IDLE), decoded directly from registered state.
- States and transitions:
  - IDLE: if start_i=1 at a clock edge, latch a_bi and b_bi, clear the accumulator and counter, go to MUL_A. Otherwise stay.
  - MUL_A: 8 cycles, one multiplier bit per cycle, LSB first. Partial product is 16 bits; sum register = a*a. Then go to MUL_B.
  - MUL_B: 8 cycles, same datapath; sum register += b*b. The sum is 17 bits; maximum 130050 does not overflow. Then go to SQRT.
  - SQRT: 9 cycles, one root bit per cycle, MSB (bit 8) first. Restoring method on the 17-bit radicand with a remainder register of at least 19 bits. Final root is at most 360.
  - SQRT, last cycle: y_bo <= root and state <= IDLE on the same edge.
- Latency: the start edge is edge 0; busy_o is high from edge 0 through edge 25, i.e. exactly 25 cycles. y_bo is valid in the first cycle busy_o=0 after an operation.
- y_bo holds its value until the next operation completes. It does not change at start or during busy; only the final SQRT edge, or rst, writes it.
- start_i while busy: ignored, with no effect on state, operands or result.
- start_i held high continuously: a new operation starts in the first IDLE cycle after completion. The core avoids this by gating with busyPrev; the block itself does not filter it.
- a_bi and b_bi are not sampled after the start edge, so changes during busy have no effect.
- rst mid-operation: next cycle state=IDLE, busy_o=0, y_bo=0; the partial computation is discarded.
- Counter: 4 bits, cleared on every state change, terminal value 7 for MUL states and 8 for SQRT.

Optional Feature:
Macro: HYP_UNIT_ROUND_EN
- Defined: result is rounded to nearest. On the final SQRT cycle, y_bo = root + 1 when the final remainder (radicand - root*root) > root, else root. Ties cannot occur for integer radicands. Maximum result is 361, which fits 9 bits. Latency stays 25 cycles; the increment is combinational in the last cycle.
- Undefined: truncating floor result as described in Behaviour; no rounding logic is synthesised.

Test Plan:
- rst, then a=3, b=4, start pulse 1 cycle -> busy_o high exactly 25 cycles; y_bo=5 when busy_o falls; y_bo stays 5 for 10 idle cycles.
- a=255, b=255 -> y_bo=360 (ROUND_EN: 361); a=0, b=0 -> y_bo=0 and busy_o still 25 cycles.
- a=2, b=3 (sum 13) -> y_bo=3 (ROUND_EN: 4); a=6, b=6 (sum 72) -> y_bo=8 in both builds.
- a=3, b=4 started, then at cycle 10 start_i=1 with a=100, b=100 -> ignored; result 5 at cycle 25; y_bo unchanged at 5 through the busy window.
- rst asserted at cycle 12 of an a=200, b=100 operation -> next cycle busy_o=0, y_bo=0; fresh a=8, b=15 start -> y_bo=17 after 25 cycles.
- Back-to-back with start_i tied high and a=5, b=12 -> y_bo=13 at cycle 25; second operation begins at the first IDLE edge and busy_o is low for exactly one cycle between runs.
